movimento_oggetto: RTL

- Upstream stage of the rectangle/frame hit-test: produces the X_POS/Y_POS of the drawn object that the hit-test compares against the scan position.
- Updates position once per video frame from four direction buttons, with per-axis acceleration and a pause mode.
- X wraps modulo H so the hit-test's right-edge wrap logic always sees X_POS in [0, H-1]. Y is clamped so the object stays on screen.
- Outputs are registered and stay stable for the whole active frame.

---
 rtl/movimento_oggetto.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/movimento_oggetto.sv
// movimento_oggetto
//   Produces the registered position of the drawn object that the downstream
//   rectangle/frame hit-test compares against the scan position. The position
//   advances once per video frame from four direction buttons. Each axis has
//   its own acceleration, and a pause mode freezes the object.
//
//   X wraps modulo H, so it is always in [0, H-1].
//   Y is clamped to [0, V-altezza].
//
// Ports
//   CLK        pixel clock
//   RESET      asynchronous, active-high reset
//   FRAME_TICK one-cycle pulse at the start of vertical blanking
//   DESTRA     move right (level, already synchronised)
//   SINISTRA   move left  (level)
//   GIU        move down  (level)
//   SU         move up    (level)
//   PAUSA      one-cycle pulse, toggles RUN/FERMO
//   X_POS      object left edge
//   Y_POS      object top edge
//   AGGIORNATO one-cycle pulse in the cycle after a processed tick
//   BORDO      last processed tick clamped Y against a screen edge
//   STATO      current FSM state (RUN=0, FERMO=1), debug visibility
//
// Handshake: there is no valid/ready pair. A tick is "processed" only when
// FRAME_TICK is high, the FSM is in RUN and PAUSA is low in that same cycle.
// Results become visible one cycle later, qualified by AGGIORNATO.
module movimento_oggetto #(
  parameter int H          = 1280,
  parameter int V          = 720,
  parameter int altezza    = 100,
  parameter int X_INIT     = 590,
  parameter int Y_INIT     = 310,
  parameter int VEL_MAX    = 8,
  parameter int ACC_FRAMES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_TICK,
  input  logic        DESTRA,
  input  logic        SINISTRA,
  input  logic        GIU,
  input  logic        SU,
  input  logic        PAUSA,
  output logic [10:0] X_POS,
  output logic [10:0] Y_POS,
  output logic        AGGIORNATO,
  output logic        BORDO,
  output logic [0:0]  STATO
);

  localparam int VW    = $clog2(VEL_MAX + 1);
  localparam int HW    = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
  localparam int Y_MAX = V - altezza;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FERMO = 1'b1;

  logic [VW-1:0] vx, vy, vx_n, vy_n;
  logic [HW-1:0] hx, hy, hx_n, hy_n;
  logic [10:0]   x_n, y_n;
  logic          bordo_n;
  logic          move_x, move_y, tick_ok;

  // Speed for this tick. A fresh press always starts at 1; afterwards speed
  // grows by one every ACC_FRAMES held ticks, saturating at VEL_MAX.
  function automatic logic [VW-1:0] speed_nxt(input logic mv,
                                               input logic [VW-1:0] v,
                                               input logic [HW-1:0] h);
    if (!mv)
      speed_nxt = '0;
    else if (v == '0)
      speed_nxt = VW'(1);
    else if (h == HW'(ACC_FRAMES - 1) && v < VW'(VEL_MAX))
      speed_nxt = v + VW'(1);
    else
      speed_nxt = v;
  endfunction

  // Hold counter, modulo ACC_FRAMES. It restarts whenever motion restarts.
  function automatic logic [HW-1:0] hold_nxt(input logic mv,
                                             input logic [VW-1:0] v,
                                             input logic [HW-1:0] h);
    if (!mv || v == '0)
      hold_nxt = '0;
    else if (h == HW'(ACC_FRAMES - 1))
      hold_nxt = '0;
    else
      hold_nxt = h + HW'(1);
  endfunction

  // Opposing buttons cancel: an axis moves only with exactly one button held.
  assign move_x  = DESTRA ^ SINISTRA;
  assign move_y  = GIU ^ SU;
  assign tick_ok = FRAME_TICK && (STATO == RUN) && !PAUSA;

  always_comb begin
    logic [11:0] xe, ye, v12x, v12y, s;
    vx_n    = speed_nxt(move_x, vx, hx);
    hx_n    = hold_nxt(move_x, vx, hx);
    vy_n    = speed_nxt(move_y, vy, hy);
    hy_n    = hold_nxt(move_y, vy, hy);
    xe      = {1'b0, X_POS};
    ye      = {1'b0, Y_POS};
    v12x    = 12'(vx_n);
    v12y    = 12'(vy_n);
    s       = '0;
    x_n     = X_POS;
    y_n     = Y_POS;
    bordo_n = 1'b0;

    // The 12-bit intermediate keeps X+v and X+H-v free of overflow.
    if (move_x && DESTRA) begin
      s   = xe + v12x;
      x_n = (s >= 12'(H)) ? 11'(s - 12'(H)) : s[10:0];
    end else if (move_x) begin
      x_n = (xe < v12x) ? 11'(xe + 12'(H) - v12x) : 11'(xe - v12x);
    end

    if (move_y && GIU) begin
      s       = ye + v12y;
      y_n     = (s > 12'(Y_MAX)) ? 11'(Y_MAX) : s[10:0];
      bordo_n = (y_n == 11'(Y_MAX));
    end else if (move_y) begin
      y_n     = (ye < v12y) ? 11'd0 : 11'(ye - v12y);
      bordo_n = (y_n == 11'd0);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      X_POS      <= 11'(X_INIT);
      Y_POS      <= 11'(Y_INIT);
      STATO      <= RUN;
      vx         <= '0;
      vy         <= '0;
      hx         <= '0;
      hy         <= '0;
      AGGIORNATO <= 1'b0;
      BORDO      <= 1'b0;
    end else begin
      AGGIORNATO <= 1'b0;
      if (PAUSA) begin
        // A coincident FRAME_TICK is dropped in either toggle direction.
        STATO <= ~STATO;
        if (STATO == RUN) begin
          vx <= '0;
          vy <= '0;
          hx <= '0;
          hy <= '0;
        end
      end else if (tick_ok) begin
        X_POS      <= x_n;
        Y_POS      <= y_n;
        vx         <= vx_n;
        vy         <= vy_n;
        hx         <= hx_n;
        hy         <= hy_n;
        BORDO      <= bordo_n;
        AGGIORNATO <= 1'b1;
      end
    end
  end

endmodule
